instruction_fetch_stage: RTL and testbench

This block is the IF stage and IF/ID pipeline register of the five-stage MIPS pipeline, sitting on the producer side of the ID-stage instruction decoder. It maintains the PC and issues word reads to a synchronous instruction memory with a one-cycle read latency. It presents the fetched instruction, PC+4 and a valid flag to the decoder. It also honours stall, flush and branch/jump redirect from the hazard and branch units.

---
 rtl/instruction_fetch_stage.sv | 69 ++++++
 tb/tb_instruction_fetch_stage.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// IF stage plus IF/ID pipeline register for the five-stage MIPS core.
// Drives a one-cycle-latency synchronous instruction memory.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 10
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_redirect,
  input  logic [31:0]            i_redirect_pc,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic                   o_imem_en,
  input  logic [31:0]            i_imem_rdata,
  output logic [31:0]            o_instruction,
  output logic [31:0]            o_pc_plus4,
  output logic                   o_valid
);

  logic [31:0] r_pc;
  logic [31:0] r_fetch_pc;
  logic        r_fetch_valid;

  logic [31:0] w_nf;
  logic        w_fetch;
  logic        w_bubble;

  // Next fetch address; redirect wins, low bits dropped.
  always_comb begin
    w_nf = i_redirect ? i_redirect_pc : r_pc;
    w_nf[1:0] = 2'b00;
  end

  // A redirect still issues its target read while stalled.
  assign w_fetch     = !i_stall | i_redirect;
  assign w_bubble    = i_flush | (i_redirect & !i_stall);
  assign o_imem_en   = w_fetch;
  assign o_imem_addr = w_nf[IMEM_ADDR_W+1:2];

  // PC and in-flight request; hold when no read is issued.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc          <= RESET_PC;
      r_fetch_pc    <= 32'h0;
      r_fetch_valid <= 1'b0;
    end else if (w_fetch) begin
      r_pc          <= w_nf + 32'd4;
      r_fetch_pc    <= w_nf;
      r_fetch_valid <= 1'b1;
    end
  end

  // IF/ID register: bubble beats stall beats normal load.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_instruction <= 32'h0;
      o_pc_plus4    <= 32'h0;
      o_valid       <= 1'b0;
    end else if (w_bubble) begin
      o_valid       <= 1'b0;
    end else if (!i_stall) begin
      o_instruction <= i_imem_rdata;
      o_pc_plus4    <= r_fetch_pc + 32'd4;
      o_valid       <= r_fetch_valid;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage.
// Memory word i holds 0x1000_0000 + i.
module tb_instruction_fetch_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, RESET_PC = 0
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redir;
  logic [31:0] redir_pc;
  logic [9:0]  addr;
  logic        en;
  logic [31:0] rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic        valid;

  // Wrap instance, RESET_PC = 0xFFFF_FFF8
  logic        rst_b;
  logic        zero_b = 1'b0;
  logic [31:0] zpc_b = 32'h0;
  logic [9:0]  addr_b;
  logic        en_b;
  logic [31:0] rdata_b = 32'h0;
  logic [31:0] instr_b;
  logic [31:0] pc4_b;
  logic        valid_b;

  instruction_fetch_stage #(
    .RESET_PC(32'h0000_0000), .IMEM_ADDR_W(10)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_stall(stall), .i_flush(flush),
    .i_redirect(redir), .i_redirect_pc(redir_pc),
    .o_imem_addr(addr), .o_imem_en(en),
    .i_imem_rdata(rdata),
    .o_instruction(instr), .o_pc_plus4(pc4),
    .o_valid(valid)
  );

  instruction_fetch_stage #(
    .RESET_PC(32'hFFFF_FFF8), .IMEM_ADDR_W(10)
  ) u_wrap (
    .i_clk(clk), .i_reset(rst_b),
    .i_stall(zero_b), .i_flush(zero_b),
    .i_redirect(zero_b), .i_redirect_pc(zpc_b),
    .o_imem_addr(addr_b), .o_imem_en(en_b),
    .i_imem_rdata(rdata_b),
    .o_instruction(instr_b), .o_pc_plus4(pc4_b),
    .o_valid(valid_b)
  );

  always @(posedge clk)
    if (en) rdata <= 32'h1000_0000 + {22'd0, addr};

  always @(posedge clk)
    if (en_b) rdata_b <= 32'h1000_0000 + {22'd0, addr_b};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int w, input logic [31:0] p4);
    exp_t e;
    e.instr = 32'h1000_0000 + w;
    e.pc4   = p4;
    q.push_back(e);
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if ({valid, instr, pc4} !== 65'h0) begin
      $display("FAIL reset_ifid got v=%b i=%h p=%h want 0/0/0",
               valid, instr, pc4);
    end else n_pass++;
    n_total++;
    if ({en, addr} !== {1'b1, 10'h000}) begin
      $display("FAIL reset_fetch got en=%b a=%h want 1/000",
               en, addr);
    end else n_pass++;
  endtask

  task automatic test_stream();
    exp_t e;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) push(k, 32'(4 * k + 4));
    tick();
    n_total++;
    if (valid !== 1'b0) begin
      $display("FAIL first_edge_valid got %b want 0", valid);
    end else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick();
      e = q.pop_front();
      n_total++;
      if ({valid, instr, pc4} !== {1'b1, e.instr, e.pc4}) begin
        $display("FAIL stream%0d got v=%b i=%h p=%h want 1/%h/%h",
                 k, valid, instr, pc4, e.instr, e.pc4);
      end else n_pass++;
    end
  endtask

  task automatic test_stall();
    exp_t e;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++;
      if (en !== 1'b0) begin
        $display("FAIL stall_en%0d got %b want 0", k, en);
      end else n_pass++;
      tick();
      n_total++;
      if ({valid, instr, pc4} !== {1'b1, 32'h1000_0003, 32'h10}) begin
        $display("FAIL stall_hold%0d got v=%b i=%h p=%h want 1/10000003/10",
                 k, valid, instr, pc4);
      end else n_pass++;
    end
    stall = 1'b0;
    push(4, 32'h14);
    push(5, 32'h18);
    for (int k = 0; k < 2; k++) begin
      tick();
      e = q.pop_front();
      n_total++;
      if ({valid, instr, pc4} !== {1'b1, e.instr, e.pc4}) begin
        $display("FAIL stall_rel%0d got v=%b i=%h p=%h want 1/%h/%h",
                 k, valid, instr, pc4, e.instr, e.pc4);
      end else n_pass++;
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    redir = 1'b1;
    redir_pc = 32'h40;
    #1;
    n_total++;
    if (addr !== 10'h010) begin
      $display("FAIL redir_addr got %h want 010", addr);
    end else n_pass++;
    tick();
    redir = 1'b0;
    n_total++;
    if ({valid, instr} !== {1'b0, 32'h1000_0005}) begin
      $display("FAIL redir_bubble got v=%b i=%h want 0/10000005",
               valid, instr);
    end else n_pass++;
    push(16, 32'h44);
    push(17, 32'h48);
    for (int k = 0; k < 2; k++) begin
      tick();
      e = q.pop_front();
      n_total++;
      if ({valid, instr, pc4} !== {1'b1, e.instr, e.pc4}) begin
        $display("FAIL redir_tgt%0d got v=%b i=%h p=%h want 1/%h/%h",
                 k, valid, instr, pc4, e.instr, e.pc4);
      end else n_pass++;
    end
  endtask

  task automatic test_stall_flush();
    exp_t e;
    stall = 1'b1;
    flush = 1'b1;
    #1;
    n_total++;
    if (addr !== 10'h013) begin
      $display("FAIL sf_addr_pre got %h want 013", addr);
    end else n_pass++;
    tick();
    flush = 1'b0;
    n_total++;
    if (valid !== 1'b0) begin
      $display("FAIL sf_bubble got %b want 0", valid);
    end else n_pass++;
    #1;
    n_total++;
    if (addr !== 10'h013) begin
      $display("FAIL sf_addr_post got %h want 013", addr);
    end else n_pass++;
    stall = 1'b0;
    push(18, 32'h4C);
    push(19, 32'h50);
    for (int k = 0; k < 2; k++) begin
      tick();
      e = q.pop_front();
      n_total++;
      if ({valid, instr, pc4} !== {1'b1, e.instr, e.pc4}) begin
        $display("FAIL sf_rel%0d got v=%b i=%h p=%h want 1/%h/%h",
                 k, valid, instr, pc4, e.instr, e.pc4);
      end else n_pass++;
    end
  endtask

  task automatic test_stall_redirect();
    exp_t e;
    stall = 1'b1;
    tick();
    redir = 1'b1;
    redir_pc = 32'h80;
    #1;
    n_total++;
    if ({en, addr} !== {1'b1, 10'h020}) begin
      $display("FAIL sr_issue got en=%b a=%h want 1/020", en, addr);
    end else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick();
      redir = 1'b0;
      n_total++;
      if ({valid, instr, pc4} !== {1'b1, 32'h1000_0013, 32'h50}) begin
        $display("FAIL sr_hold%0d got v=%b i=%h p=%h want 1/10000013/50",
                 k, valid, instr, pc4);
      end else n_pass++;
    end
    stall = 1'b0;
    push(32, 32'h84);
    push(33, 32'h88);
    for (int k = 0; k < 2; k++) begin
      tick();
      e = q.pop_front();
      n_total++;
      if ({valid, instr, pc4} !== {1'b1, e.instr, e.pc4}) begin
        $display("FAIL sr_rel%0d got v=%b i=%h p=%h want 1/%h/%h",
                 k, valid, instr, pc4, e.instr, e.pc4);
      end else n_pass++;
    end
  endtask

  task automatic test_misaligned();
    exp_t e;
    redir = 1'b1;
    redir_pc = 32'h103;
    #1;
    n_total++;
    if (addr !== 10'h040) begin
      $display("FAIL mis_addr got %h want 040", addr);
    end else n_pass++;
    tick();
    redir = 1'b0;
    push(64, 32'h104);
    tick();
    e = q.pop_front();
    n_total++;
    if ({valid, instr, pc4} !== {1'b1, e.instr, e.pc4}) begin
      $display("FAIL mis_tgt got v=%b i=%h p=%h want 1/%h/%h",
               valid, instr, pc4, e.instr, e.pc4);
    end else n_pass++;
  endtask

  task automatic test_wrap();
    exp_t e;
    n_total++;
    if ({valid_b, addr_b} !== {1'b0, 10'h3FE}) begin
      $display("FAIL wrap_rst got v=%b a=%h want 0/3fe", valid_b, addr_b);
    end else n_pass++;
    rst_b = 1'b0;
    push(1022, 32'hFFFF_FFFC);
    push(1023, 32'h0);
    push(0, 32'h4);
    tick();
    n_total++;
    if ({valid_b, addr_b} !== {1'b0, 10'h3FF}) begin
      $display("FAIL wrap_e1 got v=%b a=%h want 0/3ff", valid_b, addr_b);
    end else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick();
      e = q.pop_front();
      n_total++;
      if ({valid_b, instr_b, pc4_b} !== {1'b1, e.instr, e.pc4}) begin
        $display("FAIL wrap%0d got v=%b i=%h p=%h want 1/%h/%h",
                 k, valid_b, instr_b, pc4_b, e.instr, e.pc4);
      end else n_pass++;
    end
    rst_b = 1'b1;
    #1;
    n_total++;
    if ({valid_b, addr_b} !== {1'b0, 10'h3FE}) begin
      $display("FAIL wrap_midrst got v=%b a=%h want 0/3fe",
               valid_b, addr_b);
    end else n_pass++;
    tick();
    rst_b = 1'b0;
    push(1022, 32'hFFFF_FFFC);
    tick();
    n_total++;
    if (valid_b !== 1'b0) begin
      $display("FAIL wrap_re1 got %b want 0", valid_b);
    end else n_pass++;
    tick();
    e = q.pop_front();
    n_total++;
    if ({valid_b, instr_b, pc4_b} !== {1'b1, e.instr, e.pc4}) begin
      $display("FAIL wrap_refetch got v=%b i=%h p=%h want 1/%h/%h",
               valid_b, instr_b, pc4_b, e.instr, e.pc4);
    end else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    rst_b = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    redir = 1'b0;
    redir_pc = 32'h0;
    tick();
    tick();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_stall_flush();
    test_stall_redirect();
    test_misaligned();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
